stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM for the stopwatch counter/display datapath. Debounces two push
//  buttons (StartStop, LapReset) and sequences the counter through
//  idle/run/pause/lap. It drives the count enable, the prescaled 1/100 s tick,
//  the synchronous clear and the display freeze. Sits between board buttons
//  and the StopWatch counter block.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  cycles a synchronised button level must be stable to be accepted (>=2)
//  TICK_DIV         10  Clk cycles per Tick pulse while counting (>=2)
// PORTS
//  Clk          in   1  rising-edge clock, single clock domain
//  nReset       in   1  synchronous, active-low reset
//  BtnStartStop in   1  raw async button, active-high
//  BtnLapReset  in   1  raw async button, active-high
//  Run          out  1  counter enable; 1 in RUN and LAP
//  Tick         out  1  one-cycle count strobe to the counter
//  Clear        out  1  one-cycle synchronous clear to the counter
//  Freeze       out  1  display hold; 1 in LAP only
//  State        out  2  IDLE=00 RUN=01 PAUSE=10 LAP=11
// BEHAVIOUR
//  Reset (nReset=0 at an edge) loads all registers to 0.
//   - State=IDLE; Run, Tick, Clear and Freeze are 0.
//   - Synchronisers, debounce counters, debounced levels and prescaler are 0.
//   - A button held across reset yields one press event after release of reset.
//  Button path, per button, identical:
//   - 2-FF synchroniser feeds the debouncer.
//   - Debounce counter cnt:
//       sync2 != deb -> cnt increments.
//       sync2 != deb and cnt == DEBOUNCE_CYCLES-1 -> deb flips and cnt <= 0.
//       sync2 == deb -> cnt <= 0, so glitches shorter than DEBOUNCE_CYCLES are ignored.
//   - The event register pulses 1 cycle on a deb 0->1 edge. Release generates no event.
//   - Latency: raw first sampled high at edge 1 -> State/Run/Freeze update at edge DEBOUNCE_CYCLES+4.
//  Run and Freeze are combinational decodes of State.
//  FSM transitions, taken at the edge where the event is high:
//   - IDLE : SS -> RUN (prescaler <= 0).                LR -> IDLE, Clear pulse.
//   - RUN  : SS -> PAUSE.                               LR -> LAP.
//   - LAP  : SS -> PAUSE (Freeze drops).                LR -> RUN (Freeze drops).
//   - PAUSE: SS -> RUN (prescaler resumes, not reset).  LR -> IDLE, Clear pulse.
//  Simultaneous SS and LR events: SS wins and the LR event is discarded.
//  Clear is registered.
//   - High for exactly the cycle following the edge that enters or re-enters IDLE via LR.
//   - Never high in any other cycle.
//  Prescaler p, width clog2(TICK_DIV):
//   - Counts only in RUN and LAP and holds its value in PAUSE.
//   - Forced to 0 in IDLE.
//   - At an edge with p == TICK_DIV-1 while counting: p <= 0 and Tick <= 1. Otherwise Tick <= 0.
//   - First Tick after IDLE->RUN is high in the cycle after the TICK_DIV-th edge following entry.
//   - Subsequent Ticks follow every TICK_DIV cycles.
//   - Ticks continue uninterrupted through RUN<->LAP transitions.
//   - The transition edge into PAUSE produces no Tick.
//  Reset mid-operation: the next edge with nReset=0 forces IDLE regardless of pending events.
//   - Clear is not pulsed by reset; the counter uses its own reset.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, TICK_DIV=5)
//  1 Reset: hold nReset=0 for 2 edges -> State=00, Run=0, Tick=0, Clear=0, Freeze=0.
//  2 Start: SS high 10 cycles from IDLE -> State=01 at edge 8 after first sample.
//    Run=1. Tick pulses 5, 10, 15 cycles after entry.
//  3 Glitch: SS high for 3 cycles, then low -> no State change, no Tick, no Clear.
//  4 Lap: RUN, then press LR -> State=11, Freeze=1, Ticks keep 5-cycle spacing.
//    Press LR again -> State=01, Freeze=0.
//  5 Pause/clear: RUN 7 cycles, press SS -> State=10, no Ticks.
//    Press SS -> RUN, next Tick 3 cycles after re-entry.
//    Press SS, then LR -> State=00, Clear=1 for exactly 1 cycle.
//  6 Conflict/reset: SS and LR rise on the same cycle in RUN -> State=10 only.
//    Assert nReset=0 mid-RUN -> State=00, Run=0 at that edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces the StartStop/LapReset buttons and sequences the
// counter through IDLE/RUN/PAUSE/LAP, producing count enable, tick, clear and freeze.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 10
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       BtnStartStop,
  input  logic       BtnLapReset,
  output logic       Run,
  output logic       Tick,
  output logic       Clear,
  output logic       Freeze,
  output logic [1:0] State
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam int IDX_SS = 0;
  localparam int IDX_LR = 1;

  logic [1:0]         btn_s;
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         deb_q, deb_d, deb_prev_q, deb_prev_d, ev_q, ev_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic               tick_q, tick_d, clear_q, clear_d;
  logic               counting_s;

  assign btn_s = {BtnLapReset, BtnStartStop};

  // Synchronise, debounce and edge-detect both buttons.
  always_comb begin
    sync1_d    = btn_s;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == CNT_MAX) begin
          deb_d[b] = ~deb_q[b];
          cnt_d[b] = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end else begin
        cnt_d[b] = '0;
      end
    end
    deb_prev_d = deb_q;
    ev_d       = deb_q & ~deb_prev_q;
  end

  // Mode FSM; StartStop takes priority over a simultaneous LapReset.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_q[IDX_SS]) begin
          state_d = ST_RUN;
        end else if (ev_q[IDX_LR]) begin
          clear_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ev_q[IDX_SS]) begin
          state_d = ST_PAUSE;
        end else if (ev_q[IDX_LR]) begin
          state_d = ST_LAP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LAP: begin
        if (ev_q[IDX_SS]) begin
          state_d = ST_PAUSE;
        end else if (ev_q[IDX_LR]) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (ev_q[IDX_SS]) begin
          state_d = ST_RUN;
        end else if (ev_q[IDX_LR]) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The prescaler advances only on edges that stay in RUN/LAP, so the edge into PAUSE holds it.
  assign counting_s = ((state_q == ST_RUN) || (state_q == ST_LAP)) &&
                      ((state_d == ST_RUN) || (state_d == ST_LAP));

  // Tick prescaler.
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      pre_d = '0;
    end else if (counting_s) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      ev_q       <= 2'b00;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      tick_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      ev_q       <= ev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      clear_q    <= clear_d;
    end
  end

  assign State  = state_q;
  assign Run    = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign Freeze = (state_q == ST_LAP);
  assign Tick   = tick_q;
  assign Clear  = clear_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: presses push expected events (cycle, state,
// tick, clear) into a queue; a negedge monitor pops one per observed DUT event.
module tb_stopwatch_ctrl;

  localparam int DC  = 4;
  localparam int TD  = 5;
  localparam int LAT = DC + 3;  // first-sample edge to state-update edge
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] LAP   = 2'b11;

  logic       Clk    = 1'b0;
  logic       nReset = 1'b0;
  logic       ss     = 1'b0;
  logic       lr     = 1'b0;
  logic       run, tick, clear, freeze;
  logic [1:0] state;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       tk;
    logic       cl;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         cyc       = 0;
  int         n_cmp     = 0;
  int         n_bad     = 0;
  bit         mon_en    = 1'b0;
  bit         done      = 1'b0;
  bit         end_chk   = 1'b0;
  logic [1:0] prev_st   = 2'b00;
  logic [1:0] exp_st    = 2'b00;
  bit         counting  = 1'b0;
  int         next_tick = 0;
  int         rem       = 0;
  logic       e_run, e_frz;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .TICK_DIV(TD)) dut (
    .Clk(Clk), .nReset(nReset), .BtnStartStop(ss), .BtnLapReset(lr),
    .Run(run), .Tick(tick), .Clear(clear), .Freeze(freeze), .State(state)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [1:0] s, input logic t, input logic cl);
    exp_t x;
    x.cyc = c; x.st = s; x.tk = t; x.cl = cl;
    q.push_back(x);
  endfunction

  function automatic bit is_cnt(input logic [1:0] s);
    return (s == RUN) || (s == LAP);
  endfunction

  // Ticks fall every TD cycles while counting; push those due before cycle 'upto'.
  function automatic void flush_ticks(input int upto);
    while (counting && (next_tick < upto)) begin
      push(next_tick, exp_st, 1'b1, 1'b0);
      next_tick = next_tick + TD;
    end
  endfunction

  task automatic state_event(input int x, input logic [1:0] ns, input logic cl);
    logic tk;
    tk = 1'b0;
    flush_ticks(x);
    if (is_cnt(ns) && is_cnt(exp_st)) begin
      if (next_tick == x) begin
        tk        = 1'b1;
        next_tick = next_tick + TD;
      end
    end else if (ns == PAUSE) begin
      if (counting) rem = next_tick - x + 1;
      counting = 1'b0;
    end else if (ns == RUN) begin
      next_tick = (exp_st == IDLE) ? x + TD : x + rem;
      counting  = 1'b1;
    end else begin
      counting = 1'b0;
    end
    push(x, ns, tk, cl);
    exp_st = ns;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      flush_ticks(cyc + 2);
    end
  endtask

  task automatic press(input bit p_ss, input bit p_lr, input int hold,
                       input bit expect_ev, input logic [1:0] ns, input logic cl);
    int t;
    t  = cyc;
    ss = p_ss;
    lr = p_lr;
    if (expect_ev) state_event(t + 1 + LAT, ns, cl);
    step(hold);
    ss = 1'b0;
    lr = 1'b0;
    step(10);
  endtask

  // Monitor: a tick, clear, state change or due snapshot is one observed event.
  initial begin
    forever begin
      @(negedge Clk);
      if (mon_en && (tick || clear || (state != prev_st) || ((q.size() > 0) && (q[0].cyc == cyc)))) begin
        n_cmp = n_cmp + 1;
        if (q.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_event: cycle %0d got state=%b tick=%b clear=%b, none expected",
                   cyc, state, tick, clear);
        end else begin
          e     = q.pop_front();
          e_run = (e.st == RUN) || (e.st == LAP);
          e_frz = (e.st == LAP);
          if ((e.cyc != cyc) || (state !== e.st) || (run !== e_run) || (freeze !== e_frz) ||
              (tick !== e.tk) || (clear !== e.cl)) begin
            n_bad = n_bad + 1;
            $display("FAIL event_c%0d: got cyc=%0d state=%b run=%b freeze=%b tick=%b clear=%b, want cyc=%0d state=%b run=%b freeze=%b tick=%b clear=%b",
                     e.cyc, cyc, state, run, freeze, tick, clear, e.cyc, e.st, e_run, e_frz, e.tk, e.cl);
          end
        end
      end
      if (done && !end_chk) begin
        end_chk = 1'b1;
        n_cmp   = n_cmp + 1;
        if (q.size() != 0) begin
          n_bad = n_bad + 1;
          $display("FAIL leftover: %0d expected events never seen, required 0 (next at cycle %0d)",
                   q.size(), q[0].cyc);
        end
      end
      prev_st = state;
    end
  end

  // Stimulus.
  initial begin
    step(3);
    push(cyc, IDLE, 1'b0, 1'b0);
    mon_en = 1'b1;
    nReset = 1'b1;
    step(2);
    press(1'b1, 1'b0, 3,  1'b0, IDLE,  1'b0);  // glitch: ignored
    press(1'b0, 1'b1, 6,  1'b1, IDLE,  1'b1);  // LR in IDLE: clear only
    press(1'b1, 1'b0, 10, 1'b1, RUN,   1'b0);  // start
    press(1'b0, 1'b1, 6,  1'b1, LAP,   1'b0);  // lands on a tick edge
    press(1'b0, 1'b1, 6,  1'b1, RUN,   1'b0);
    step(1);
    press(1'b1, 1'b0, 6,  1'b1, PAUSE, 1'b0);
    press(1'b1, 1'b0, 6,  1'b1, RUN,   1'b0);  // next tick 3 after re-entry
    step(2);
    press(1'b1, 1'b0, 6,  1'b1, PAUSE, 1'b0);  // pause edge where a tick was due
    press(1'b0, 1'b1, 6,  1'b1, IDLE,  1'b1);
    press(1'b1, 1'b0, 6,  1'b1, RUN,   1'b0);
    press(1'b1, 1'b1, 6,  1'b1, PAUSE, 1'b0);  // simultaneous: SS wins
    press(1'b1, 1'b0, 6,  1'b1, RUN,   1'b0);
    nReset = 1'b0;
    state_event(cyc + 1, IDLE, 1'b0);
    step(2);
    nReset = 1'b1;
    step(12);
    done = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
